multiplexer_3to1: RTL and testbench

// - Registered 32-bit 3-to-1 data selector on the multicycle MIPS datapath (e.g. PC-source / write-data select).
// - Picks one of three operand words by a 2-bit code; registers the choice so the result is stable for a whole cycle.
// - One clock domain; asynchronous active-low reset.

---
 rtl/multiplexer_3to1.sv | 81 ++++++++
 tb/tb_multiplexer_3to1.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multiplexer_3to1.sv
// Registered 32-bit 3-to-1 word selector with a sticky illegal-select flag.
// Optional feature: define MULTIPLEXER_SELECT_CHECK_EN to enable sel_err tracking.
module multiplexer_3to1 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [WIDTH-1:0] input3,
    input  logic [1:0]       signal,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             sel_err
);

    localparam logic [1:0] SEL_IN1 = 2'b00;
    localparam logic [1:0] SEL_IN2 = 2'b01;
    localparam logic [1:0] SEL_IN3 = 2'b10;

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_illegal_s;
    logic [WIDTH-1:0] result_r;
    logic             out_valid_r;

    // Decode the select code; anything other than a legal code (including X) yields zero.
    always_comb begin
        sel_data_s    = {WIDTH{1'b0}};
        sel_illegal_s = 1'b0;
        case (signal)
            SEL_IN1: sel_data_s = input1;
            SEL_IN2: sel_data_s = input2;
            SEL_IN3: sel_data_s = input3;
            default: begin
                sel_data_s    = {WIDTH{1'b0}};
                sel_illegal_s = 1'b1;
            end
        endcase
    end

    // Capture the selected word only on qualified cycles; valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                result_r <= sel_data_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

`ifdef MULTIPLEXER_SELECT_CHECK_EN
    logic sel_err_r;

    // Sticky flag: once an illegal code is accepted it stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (in_valid && sel_illegal_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign sel_err = sel_err_r;
`else
    logic unused_illegal_s;
    assign unused_illegal_s = sel_illegal_s;
    assign sel_err          = 1'b0;
`endif

    assign result    = result_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_multiplexer_3to1.sv
// Directed self-checking bench for multiplexer_3to1 (works with or without MULTIPLEXER_SELECT_CHECK_EN).
module tb_multiplexer_3to1;

    logic        clk;
    logic        rst_n;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [31:0] input3;
    logic [1:0]  signal;
    logic        in_valid;
    logic [31:0] result;
    logic        out_valid;
    logic        sel_err;

    int tests_run_r;
    int tests_failed_r;
    logic exp_err_s;

    multiplexer_3to1 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input1    (input1),
        .input2    (input2),
        .input3    (input3),
        .signal    (signal),
        .in_valid  (in_valid),
        .result    (result),
        .out_valid (out_valid),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run_r = tests_run_r + 1;
        if (got !== exp) begin
            tests_failed_r = tests_failed_r + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run_r    = 0;
        tests_failed_r = 0;
`ifdef MULTIPLEXER_SELECT_CHECK_EN
        exp_err_s = 1'b1;
`else
        exp_err_s = 1'b0;
`endif
        rst_n    = 1'b0;
        input1   = 32'h0000_0000;
        input2   = 32'h0000_0000;
        input3   = 32'h0000_0000;
        signal   = 2'b00;
        in_valid = 1'b0;
        #2;
        check("rst_result", result, 32'h0000_0000);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sel_err", {31'd0, sel_err}, 32'd0);
        #1 rst_n = 1'b1;

        // all-zero inputs
        in_valid = 1'b1;
        tick();
        check("zero_result", result, 32'h0000_0000);
        check("zero_out_valid", {31'd0, out_valid}, 32'd1);
        check("zero_sel_err", {31'd0, sel_err}, 32'd0);

        // select sweep
        input1 = 32'h1111_1111;
        input2 = 32'h2222_2222;
        input3 = 32'h3333_3333;
        signal = 2'b00;
        tick();
        check("sweep00", result, 32'h1111_1111);
        check("sweep00_ov", {31'd0, out_valid}, 32'd1);
        signal = 2'b01;
        tick();
        check("sweep01", result, 32'h2222_2222);
        check("sweep01_ov", {31'd0, out_valid}, 32'd1);

        // hold while not valid
        in_valid = 1'b0;
        signal   = 2'b10;
        input2   = 32'h0000_0000;
        tick();
        check("hold_result", result, 32'h2222_2222);
        check("hold_ov", {31'd0, out_valid}, 32'd0);
        signal = 2'bxx;
        tick();
        check("hold_x_result", result, 32'h2222_2222);

        in_valid = 1'b1;
        signal   = 2'b10;
        tick();
        check("sweep10", result, 32'h3333_3333);
        check("sweep10_ov", {31'd0, out_valid}, 32'd1);

        // asynchronous reset mid-cycle
        input1 = 32'hDEAD_BEEF;
        signal = 2'b00;
        tick();
        check("pre_rst_result", result, 32'hDEAD_BEEF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_result", result, 32'h0000_0000);
        check("async_rst_ov", {31'd0, out_valid}, 32'd0);
        check("async_rst_err", {31'd0, sel_err}, 32'd0);
        rst_n = 1'b1;

        // illegal code after a nonzero result
        signal = 2'b10;
        tick();
        check("pre_illegal", result, 32'h3333_3333);
        signal = 2'b11;
        tick();
        check("illegal_result", result, 32'h0000_0000);
        check("illegal_ov", {31'd0, out_valid}, 32'd1);
        check("illegal_err", {31'd0, sel_err}, {31'd0, exp_err_s});
        input1 = 32'h4444_4444;
        signal = 2'b00;
        tick();
        check("after_illegal", result, 32'h4444_4444);
        check("sticky_err", {31'd0, sel_err}, {31'd0, exp_err_s});

        // reset clears sticky flag
        #2 rst_n = 1'b0;
        #1;
        check("clear_err", {31'd0, sel_err}, 32'd0);
        rst_n  = 1'b1;
        input1 = 32'hA5A5_A5A5;
        signal = 2'b00;
        tick();
        check("post_clear_result", result, 32'hA5A5_A5A5);
        check("post_clear_err", {31'd0, sel_err}, 32'd0);
        in_valid = 1'b0;
        tick();
        check("idle_ov", {31'd0, out_valid}, 32'd0);
        check("idle_result", result, 32'hA5A5_A5A5);

        $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
        $finish;
    end

endmodule
